axi_stream_slave_fifo_wr: RTL and testbench

AXI_STREAM_SLAVE_FIFO_WR -- requirements
Module: axi_stream_slave_fifo_wr

---
 rtl/axi_stream_slave_fifo_wr.sv | 110 +++++++++++
 tb/tb_axi_stream_slave_fifo_wr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_slave_fifo_wr.sv
// AXI-Stream slave that pushes beats into a downstream FIFO through a single
// holding register, and checks each frame against a fixed length.
module axi_stream_slave_fifo_wr #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FrameSize            = 8
) (
    input  logic                              s_axis_aclk,
    input  logic                              s_axis_areset,
    input  logic                              s_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              fifo_full,
    output logic                              fifo_write_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   fifo_write_data,
    output logic                              frame_done,
    output logic                              frame_err,
    output logic [15:0]                       frame_count,
    output logic [1:0]                        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FrameSize - 1);

    // Handshake: a beat transfers on any rising edge where s_axis_tvalid and
    // s_axis_tready are both 1; the FIFO is written where fifo_write_en is 1.
    state_t                            state;
    logic [7:0]                        beat_cnt;
    logic                              hold_valid;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   hold_data;
    logic                              accept;
    logic                              forward;
    logic                              unused_strb;

    assign unused_strb     = ^s_axis_tstrb;
    assign fifo_write_en   = hold_valid & ~fifo_full;
    assign fifo_write_data = hold_data;
    // Ready while the slot is empty or being drained this cycle, even in DROP.
    assign s_axis_tready   = ~hold_valid | fifo_write_en;
    assign accept          = s_axis_tvalid & s_axis_tready;
    assign forward         = accept & (state != DROP);
    assign state_dbg       = state;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (forward) begin
            hold_valid <= 1'b1;
            hold_data  <= s_axis_tdata;
        end else if (fifo_write_en) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state       <= IDLE;
            beat_cnt    <= 8'd0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (s_axis_tlast) begin
                            frame_err <= 1'b1;
                        end else begin
                            state    <= RECV;
                            beat_cnt <= 8'd1;
                        end
                    end
                    RECV: begin
                        if (beat_cnt == LAST_IDX) begin
                            beat_cnt <= 8'd0;
                            if (s_axis_tlast) begin
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                state       <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= DROP;
                            end
                        end else if (s_axis_tlast) begin
                            frame_err <= 1'b1;
                            beat_cnt  <= 8'd0;
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_slave_fifo_wr.sv
// Directed bench for axi_stream_slave_fifo_wr: inputs change 2 ns after the
// rising edge, a monitor records writes/accepts/pulses on the falling edge.
module tb_axi_stream_slave_fifo_wr;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b0;
    logic [W-1:0]  tdata = '0;
    logic [W/8-1:0] tstrb = '1;
    logic          tlast = 1'b0;
    logic          tready;
    logic          fifo_full = 1'b0;
    logic          fifo_write_en;
    logic [W-1:0]  fifo_write_data;
    logic          frame_done;
    logic          frame_err;
    logic [15:0]   frame_count;
    logic [1:0]    state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_q[$];
    int           wrc_q[$];
    int           acc_q[$];
    int           done_n = 0;
    int           err_n = 0;
    int           err_cyc = -1;
    int           cyc = 0;

    always #5 clk = ~clk;

    axi_stream_slave_fifo_wr #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .FrameSize(8)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_areset  (rst),
        .s_axis_tvalid  (tvalid),
        .s_axis_tdata   (tdata),
        .s_axis_tstrb   (tstrb),
        .s_axis_tlast   (tlast),
        .s_axis_tready  (tready),
        .fifo_full      (fifo_full),
        .fifo_write_en  (fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .frame_count    (frame_count),
        .state_dbg      (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: on the falling edge, inputs and outputs are settled for the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (tvalid && tready) acc_q.push_back(cyc);
            if (fifo_write_en) begin
                wr_q.push_back(fifo_write_data);
                wrc_q.push_back(cyc);
            end
            if (frame_done) done_n++;
            if (frame_err) begin
                err_n++;
                err_cyc = cyc;
            end
            if (frame_done || frame_err) chk("pulse_excl", {31'd0, frame_done & frame_err}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr();
        exp_q.delete();
        wr_q.delete();
        wrc_q.delete();
        acc_q.delete();
        done_n  = 0;
        err_n   = 0;
        err_cyc = -1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int w;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        w = 0;
        while (!tready && w < 50) begin
            step(1);
            w++;
        end
        chk("ready_timeout", {31'd0, tready}, 32'd1);
        step(1);
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int n, input int last_pos);
        for (int i = 1; i <= n; i++) send_beat(base + W'(i - 1), (i == last_pos));
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_data"}, (i < wr_q.size()) ? wr_q[i] : 'x, exp_q[i]);
    endtask

    initial begin
        // Reset state, with tvalid high to show tready is 1 during reset
        step(1);
        tvalid = 1'b1;
        #1;
        chk("rst_tready", {31'd0, tready}, 32'd1);
        chk("rst_wr_en", {31'd0, fifo_write_en}, 32'd0);
        chk("rst_wr_data", fifo_write_data, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        tvalid = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);

        // Good 8-beat frame, full throughput
        clr();
        send_frame(32'd1, 8, 8);
        step(3);
        for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
        check_writes("t1");
        if (wrc_q.size() == 8 && acc_q.size() == 8) begin
            chk("t1_latency", wrc_q[0] - acc_q[0], 32'd1);
            chk("t1_consec", wrc_q[7] - wrc_q[0], 32'd7);
            chk("t1_acc_consec", acc_q[7] - acc_q[0], 32'd7);
        end
        chk("t1_done", done_n, 32'd1);
        chk("t1_err", err_n, 32'd0);
        chk("t1_count", {16'd0, frame_count}, 32'd1);

        // Back-pressure after the second beat
        clr();
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        fifo_full = 1'b1;
        tvalid    = 1'b1;
        tdata     = 32'd3;
        tlast     = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready_low", {31'd0, tready}, 32'd0);
            chk("t2_hold_data", fifo_write_data, 32'd2);
            chk("t2_wr_en_low", {31'd0, fifo_write_en}, 32'd0);
            step(1);
            #1;
        end
        fifo_full = 1'b0;
        #1;
        chk("t2_ready_back", {31'd0, tready}, 32'd1);
        chk("t2_wr_en_back", {31'd0, fifo_write_en}, 32'd1);
        send_beat(32'd3, 1'b0);
        for (int i = 4; i <= 8; i++) send_beat(W'(i), (i == 8));
        tvalid = 1'b0;
        tlast  = 1'b0;
        step(3);
        for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
        check_writes("t2");
        chk("t2_done", done_n, 32'd1);
        chk("t2_count", {16'd0, frame_count}, 32'd2);

        // Early tlast on beat 5, then a good frame
        clr();
        send_frame(32'd1, 5, 5);
        step(3);
        for (int i = 1; i <= 5; i++) exp_q.push_back(W'(i));
        check_writes("t3");
        chk("t3_err", err_n, 32'd1);
        chk("t3_done", done_n, 32'd0);
        if (acc_q.size() == 5) chk("t3_err_cycle", err_cyc, acc_q[4] + 1);
        chk("t3_count", {16'd0, frame_count}, 32'd2);
        chk("t3_state", {30'd0, state_dbg}, 32'd0);
        clr();
        send_frame(32'd11, 8, 8);
        step(3);
        for (int i = 11; i <= 18; i++) exp_q.push_back(W'(i));
        check_writes("t3b");
        chk("t3b_done", done_n, 32'd1);
        chk("t3b_count", {16'd0, frame_count}, 32'd3);

        // Overlong 11-beat frame: first 8 written, the rest dropped
        clr();
        send_frame(32'd21, 11, 11);
        step(3);
        for (int i = 21; i <= 28; i++) exp_q.push_back(W'(i));
        check_writes("t4");
        chk("t4_err", err_n, 32'd1);
        chk("t4_done", done_n, 32'd0);
        chk("t4_acc", acc_q.size(), 32'd11);
        if (acc_q.size() == 11) chk("t4_err_cycle", err_cyc, acc_q[7] + 1);
        chk("t4_state", {30'd0, state_dbg}, 32'd0);
        chk("t4_count", {16'd0, frame_count}, 32'd3);

        // Reset mid-frame while the FIFO is full
        clr();
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        tvalid    = 1'b0;
        fifo_full = 1'b1;
        step(1);
        chk("t5_held", {31'd0, tready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_tready", {31'd0, tready}, 32'd1);
        chk("t5_rst_wr_en", {31'd0, fifo_write_en}, 32'd0);
        chk("t5_rst_wr_data", fifo_write_data, 32'd0);
        chk("t5_rst_done", {31'd0, frame_done}, 32'd0);
        chk("t5_rst_err", {31'd0, frame_err}, 32'd0);
        chk("t5_rst_count", {16'd0, frame_count}, 32'd0);
        chk("t5_rst_state", {30'd0, state_dbg}, 32'd0);
        step(1);
        rst       = 1'b0;
        fifo_full = 1'b0;
        step(1);
        clr();
        send_frame(32'd41, 8, 8);
        step(3);
        for (int i = 41; i <= 48; i++) exp_q.push_back(W'(i));
        check_writes("t5");
        chk("t5_done", done_n, 32'd1);
        chk("t5_err", err_n, 32'd0);
        chk("t5_count", {16'd0, frame_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
